demux_1_4: RTL and testbench

1-to-4 demultiplexer: steers a single data bit `a` to one of four outputs selected by the 2-bit select `{u, v}`; the unselected outputs are driven 0. The combinational routing path has zero latency. A clocked monitor stage adds a registered copy of the outputs, sticky per-channel hit flags and optional per-channel activity counters. Used as a generic bit-steering leaf in decode and enable fan-out logic.

---
 rtl/demux_1_4_if.sv | 16 +
 rtl/demux_1_4.sv | 91 +++++++++
 tb/tb_demux_1_4.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/demux_1_4_if.sv
// Signal bundle for one demux_1_4 instance: steering inputs, routed bits and monitor readback.
// master drives select/data/control; slave is the demux side.
interface demux_1_4_if;
   logic       a;
   logic       u;
   logic       v;
   logic [3:0] y;
   logic       clr;
   logic [3:0] y_q;
   logic [3:0] hit;
   logic [1:0] cnt_sel;
   logic [7:0] cnt_out;

   modport master (output a, u, v, clr, cnt_sel, input y, y_q, hit, cnt_out);
   modport slave  (input a, u, v, clr, cnt_sel, output y, y_q, hit, cnt_out);
endinterface

// File: rtl/demux_1_4.sv
// 1-to-4 bit demux with registered output copy, sticky hit flags and, with DEMUX_ACT_CNT_EN,
// saturating rising-edge counters. Routing: 0 cycles; monitor: 1 cycle. No backpressure.
// Ports stay discrete and in legacy order so existing positional instantiations keep working.
module demux_1_4 (
   input  logic       a,
   input  logic       u,
   input  logic       v,
   output logic       y0,
   output logic       y1,
   output logic       y2,
   output logic       y3,
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   output logic [3:0] y_q,
   output logic [3:0] hit,
   input  logic [1:0] cnt_sel,
   output logic [7:0] cnt_out
);

   logic [3:0] y_vec;
   logic [3:0] y_q_d, y_q_q;
   logic [3:0] hit_d, hit_q;

   // Explicit per-code decode; a non-binary select falls to the all-zero default.
   always_comb begin
      y_vec = 4'b0000;
      case ({u, v})
         2'b00:   y_vec[0] = a;
         2'b01:   y_vec[1] = a;
         2'b10:   y_vec[2] = a;
         2'b11:   y_vec[3] = a;
         default: y_vec = 4'b0000;
      endcase
   end

   assign y0 = y_vec[0];
   assign y1 = y_vec[1];
   assign y2 = y_vec[2];
   assign y3 = y_vec[3];

   always_comb begin
      y_q_d = y_vec;
      hit_d = clr ? 4'b0000 : (hit_q | y_vec);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q_q <= 4'b0000;
         hit_q <= 4'b0000;
      end else begin
         y_q_q <= y_q_d;
         hit_q <= hit_d;
      end
   end

   assign y_q = y_q_q;
   assign hit = hit_q;

`ifdef DEMUX_ACT_CNT_EN
   logic [7:0] cnt_d [4];
   logic [7:0] cnt_q [4];

   // Count sampled rising edges only: current bit high, previous sample low.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = cnt_q[i];
         if (clr) begin
            cnt_d[i] = 8'h00;
         end else if (y_vec[i] && !y_q_q[i] && (cnt_q[i] != 8'hff)) begin
            cnt_d[i] = cnt_q[i] + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= 8'h00;
      end else begin
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign cnt_out = cnt_q[cnt_sel];
`else
   logic unused_cnt_sel;
   assign unused_cnt_sel = ^cnt_sel;
   assign cnt_out        = 8'h00;
`endif

endmodule

// File: tb/tb_demux_1_4.sv
// Directed bench for demux_1_4: combinational routing, monitor registers, reset, clr and counters.
module tb_demux_1_4;
   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;

   demux_1_4_if dif ();

   demux_1_4 dut (
      .a       (dif.a),
      .u       (dif.u),
      .v       (dif.v),
      .y0      (dif.y[0]),
      .y1      (dif.y[1]),
      .y2      (dif.y[2]),
      .y3      (dif.y[3]),
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (dif.clr),
      .y_q     (dif.y_q),
      .hit     (dif.hit),
      .cnt_sel (dif.cnt_sel),
      .cnt_out (dif.cnt_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs are applied 1 time unit after a rising edge, so the next edge samples them.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_sel(input logic [1:0] s);
      dif.u = s[1];
      dif.v = s[0];
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n       = 1'b0;
      dif.a       = 1'b0;
      dif.clr     = 1'b0;
      dif.cnt_sel = 2'd0;
      set_sel(2'b00);
      #1;
      chk("reset_y_q", {28'd0, dif.y_q}, 32'h0);
      chk("reset_hit", {28'd0, dif.hit}, 32'h0);
      chk("reset_cnt", {24'd0, dif.cnt_out}, 32'h0);
      step();
      rst_n = 1'b1;
      step();

      // a=0: nothing routed, nothing recorded
      for (int s = 0; s < 4; s++) begin
         set_sel(s[1:0]);
         #1;
         chk("a0_y", {28'd0, dif.y}, 32'h0);
         step();
      end
      chk("a0_hit", {28'd0, dif.hit}, 32'h0);
      chk("a0_y_q", {28'd0, dif.y_q}, 32'h0);

      // a=1 sweep: one-hot routing, one sampled edge per select value
      dif.a = 1'b1;
      for (int s = 0; s < 4; s++) begin
         set_sel(s[1:0]);
         #1;
         chk("a1_y", {28'd0, dif.y}, 32'h1 << s);
         step();
         chk("a1_y_q", {28'd0, dif.y_q}, 32'h1 << s);
      end
      chk("sweep_hit", {28'd0, dif.hit}, 32'hf);
`ifdef DEMUX_ACT_CNT_EN
      for (int s = 0; s < 4; s++) begin
         dif.cnt_sel = s[1:0];
         #1;
         chk("sweep_cnt", {24'd0, dif.cnt_out}, 32'h1);
      end
`endif

      // asynchronous reset mid-run; routing keeps following inputs
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_y_q", {28'd0, dif.y_q}, 32'h0);
      chk("arst_hit", {28'd0, dif.hit}, 32'h0);
      chk("arst_cnt", {24'd0, dif.cnt_out}, 32'h0);
      chk("arst_y3", {28'd0, dif.y}, 32'h8);
      set_sel(2'b01);
      #1;
      chk("arst_y1", {28'd0, dif.y}, 32'h2);
      step();
      chk("arst_hold_y_q", {28'd0, dif.y_q}, 32'h0);
      chk("arst_hold_hit", {28'd0, dif.hit}, 32'h0);
      rst_n = 1'b1;
      dif.a = 1'b0;
      step();

      // three pulses on channel 2
      set_sel(2'b10);
      dif.cnt_sel = 2'd2;
      for (int k = 0; k < 3; k++) begin
         dif.a = 1'b1;
         step();
         chk("pulse_y_q", {28'd0, dif.y_q}, 32'h4);
         dif.a = 1'b0;
         step();
      end
      chk("pulse_hit", {28'd0, dif.hit}, 32'h4);
      chk("pulse_y_q0", {28'd0, dif.y_q}, 32'h0);
`ifdef DEMUX_ACT_CNT_EN
      chk("pulse_cnt", {24'd0, dif.cnt_out}, 32'h3);
`else
      chk("pulse_cnt_off", {24'd0, dif.cnt_out}, 32'h0);
`endif

      // clr beats a simultaneous rising edge; y_q still samples
      dif.clr = 1'b1;
      dif.a   = 1'b1;
      step();
      chk("clr_hit", {28'd0, dif.hit}, 32'h0);
      chk("clr_cnt", {24'd0, dif.cnt_out}, 32'h0);
      chk("clr_y_q", {28'd0, dif.y_q}, 32'h4);
      dif.clr = 1'b0;
      step();
      chk("post_clr_hit", {28'd0, dif.hit}, 32'h4);
      chk("post_clr_cnt", {24'd0, dif.cnt_out}, 32'h0);
      dif.a = 1'b0;
      step();

      // steady high counts once, then saturation on channel 3
      set_sel(2'b11);
      dif.cnt_sel = 2'd3;
      dif.a = 1'b1;
      repeat (10) step();
      chk("hold_hit", {28'd0, dif.hit}, 32'hc);
`ifdef DEMUX_ACT_CNT_EN
      chk("hold_cnt", {24'd0, dif.cnt_out}, 32'h1);
`endif
      for (int k = 0; k < 253; k++) begin
         dif.a = 1'b0;
         step();
         dif.a = 1'b1;
         step();
      end
`ifdef DEMUX_ACT_CNT_EN
      chk("cnt_254", {24'd0, dif.cnt_out}, 32'd254);
`endif
      dif.a = 1'b0;
      step();
      dif.a = 1'b1;
      step();
`ifdef DEMUX_ACT_CNT_EN
      chk("cnt_255", {24'd0, dif.cnt_out}, 32'd255);
`endif
      for (int k = 0; k < 46; k++) begin
         dif.a = 1'b0;
         step();
         dif.a = 1'b1;
         step();
      end
`ifdef DEMUX_ACT_CNT_EN
      chk("cnt_sat", {24'd0, dif.cnt_out}, 32'd255);
`endif
      chk("final_y_q", {28'd0, dif.y_q}, 32'h8);

      // readback of every channel
      for (int s = 0; s < 4; s++) begin
         dif.cnt_sel = s[1:0];
         #1;
`ifdef DEMUX_ACT_CNT_EN
         chk("readback", {24'd0, dif.cnt_out}, (s == 3) ? 32'd255 : 32'd0);
`else
         chk("readback_off", {24'd0, dif.cnt_out}, 32'h0);
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
